// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the core MEM stage and a host/loader port.
// The core has priority; host bursts are bounded and a blocked host gets a forced slot.
module data_memory_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int WAIT_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int WAIT_W  = $clog2(WAIT_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    HOST = 2'd2
  } ownerState_t;

  ownerState_t        state;
  ownerState_t        nextState;
  logic [BURST_W-1:0] burstCnt;
  logic [BURST_W-1:0] nextBurst;
  logic [WAIT_W-1:0]  waitCnt;
  logic [WAIT_W-1:0]  nextWait;
  logic               grantCore;
  logic               grantHost;

  // Grant is decided within the cycle from registered state and the live requests.
  always_comb begin
    grantCore = 1'b0;
    grantHost = 1'b0;
    nextState = state;
    nextBurst = burstCnt;
    nextWait  = waitCnt;
    if (reset) begin
      case (state)
        IDLE: begin
          if (core_req) begin
            grantCore = 1'b1;
            nextState = CORE;
            nextWait  = WAIT_W'(host_req);
          end else if (host_req) begin
            grantHost = 1'b1;
            nextState = HOST;
            nextBurst = BURST_W'(1);
          end
        end
        CORE: begin
          if (host_req && (!core_req || waitCnt == WAIT_LIMIT)) begin
            grantHost = 1'b1;
            nextState = HOST;
            nextBurst = BURST_W'(1);
            nextWait  = '0;
          end else if (core_req) begin
            grantCore = 1'b1;
            if (!host_req)
              nextWait = '0;
            else if (waitCnt != WAIT_LIMIT)
              nextWait = waitCnt + WAIT_W'(1);
          end else begin
            nextState = IDLE;
            nextWait  = '0;
          end
        end
        HOST: begin
          // Saturating the burst count keeps a lone host from ever being throttled.
          if (host_req && !(core_req && burstCnt == BURST_LIMIT)) begin
            grantHost = 1'b1;
            if (burstCnt != BURST_LIMIT)
              nextBurst = burstCnt + BURST_W'(1);
          end else if (core_req) begin
            grantCore = 1'b1;
            nextState = CORE;
            nextBurst = '0;
            nextWait  = WAIT_W'(host_req);
          end else begin
            nextState = IDLE;
            nextBurst = '0;
          end
        end
        default: begin
          nextState = IDLE;
          nextBurst = '0;
          nextWait  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      burstCnt <= '0;
      waitCnt  <= '0;
    end else begin
      state    <= nextState;
      burstCnt <= nextBurst;
      waitCnt  <= nextWait;
    end
  end

  assign mem_addr   = grantHost ? host_addr  : core_addr;
  assign mem_wdata  = grantHost ? host_wdata : core_wdata;
  assign mem_we     = (grantHost & host_we) | (grantCore & core_we);
  assign host_ack   = grantHost;
  assign core_stall = reset & core_req & ~grantCore;
  assign core_rdata = mem_rdata;
  assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized and directed bench for data_memory_arbiter against an ownership/fairness
// model built from grant history (previous owner, host run length, host blocked count).
module tb_data_memory_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int MB = 16;
  localparam int WM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, host_req, host_we;
  logic [AW-1:0] core_addr, host_addr, mem_addr;
  logic [DW-1:0] core_wdata, host_wdata, core_rdata, host_rdata, mem_wdata, mem_rdata;
  logic          core_stall, host_ack, mem_we;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory driven by the DUT, plus an independent reference image driven by the model.
  logic [DW-1:0] memArr [0:(1<<AW)-1];
  logic [DW-1:0] refMem [0:(1<<AW)-1];
  assign mem_rdata = memArr[mem_addr];
  always @(posedge clk) if (mem_we) memArr[mem_addr] <= mem_wdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, req, $time);
    end
  endtask

  // Model state: 0 = nobody granted last cycle, 1 = core, 2 = host.
  int prevOwner = 0;
  int hostRun = 0;
  int blocked = 0;
  bit expCore, expHost;
  bit sReset = 1'b0, sHostReq, sWrite;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sData;

  initial forever begin
    @(negedge clk);
    expCore = 1'b0;
    expHost = 1'b0;
    if (reset === 1'b1) begin
      if (prevOwner == 0) begin
        if (core_req) expCore = 1'b1;
        else if (host_req) expHost = 1'b1;
      end else if (prevOwner == 1) begin
        if (host_req && (!core_req || blocked >= WM)) expHost = 1'b1;
        else if (core_req) expCore = 1'b1;
      end else begin
        if (host_req && !(core_req && hostRun >= MB)) expHost = 1'b1;
        else if (core_req) expCore = 1'b1;
      end
    end
    chk("host_ack", 32'(host_ack), 32'(expHost));
    chk("core_stall", 32'(core_stall), 32'(reset === 1'b1 && core_req && !expCore));
    chk("mem_we", 32'(mem_we), 32'((expHost && host_we) || (expCore && core_we)));
    sWrite = 1'b0;
    if (expHost) begin
      chk("mem_addr_h", 32'(mem_addr), 32'(host_addr));
      if (host_we) begin
        chk("mem_wdata_h", 32'(mem_wdata), 32'(host_wdata));
        sWrite = 1'b1; sAddr = host_addr; sData = host_wdata;
      end else chk("host_rdata", 32'(host_rdata), 32'(refMem[host_addr]));
    end
    if (expCore) begin
      chk("mem_addr_c", 32'(mem_addr), 32'(core_addr));
      if (core_we) begin
        chk("mem_wdata_c", 32'(mem_wdata), 32'(core_wdata));
        sWrite = 1'b1; sAddr = core_addr; sData = core_wdata;
      end else chk("core_rdata", 32'(core_rdata), 32'(refMem[core_addr]));
    end
    sReset = reset;
    sHostReq = host_req;
  end

  initial forever begin
    @(posedge clk);
    if (!sReset) begin
      prevOwner = 0; hostRun = 0; blocked = 0;
    end else begin
      if (sWrite) refMem[sAddr] = sData;
      prevOwner = expCore ? 1 : (expHost ? 2 : 0);
      hostRun = expHost ? ((hostRun + 1 > MB) ? MB : hostRun + 1) : 0;
      blocked = (expCore && sHostReq) ? blocked + 1 : 0;
    end
  end

  task automatic cycle(input bit rst, input bit cr, input bit cw, input int ca, input int cd,
                       input bit hr, input bit hw, input int ha, input int hd);
    @(posedge clk);
    #1;
    reset = rst; core_req = cr; core_we = cw; core_addr = AW'(ca); core_wdata = DW'(cd);
    host_req = hr; host_we = hw; host_addr = AW'(ha); host_wdata = DW'(hd);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [DW-1:0] pattern(input int i);
    return DW'((i * 16'h0101) ^ 16'h5A5A);
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      memArr[i] = '0;
      refMem[i] = '0;
    end
    reset = 0; core_req = 1; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 1; host_we = 1; host_addr = AW'(5); host_wdata = 16'hAAAA;

    // Reset held with both requesters active and a host write pending.
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 0, 0, 1, 1, 5, 16'hAAAA);
      chk("rst_ack", 32'(host_ack), 32'd0);
      chk("rst_stall", 32'(core_stall), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
    end
    cycle(1, 1, 0, 'h10, 0, 1, 1, 5, 16'hAAAA);
    chk("rel_core_first", 32'(core_stall), 32'd0);
    chk("rel_ack", 32'(host_ack), 32'd0);

    // Core-only store then load.
    idle();
    cycle(1, 1, 1, 'h010, 'h1234, 0, 0, 0, 0);
    chk("st_stall", 32'(core_stall), 32'd0);
    chk("st_we", 32'(mem_we), 32'd1);
    cycle(1, 1, 0, 'h010, 0, 0, 0, 0, 0);
    chk("ld_data", 32'(core_rdata), 32'h1234);
    chk("ld_stall", 32'(core_stall), 32'd0);

    // Both request from IDLE: the blocked count reaches WAIT_MAX after four core grants.
    idle();
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 1, 0, i, 0, 1, 0, 'h100, 0);
      chk("starve_ack", 32'(host_ack), 32'(i == 5));
      chk("starve_stall", 32'(core_stall), 32'(i == 5));
    end

    // 20-write host burst; core joins on cycle 3 and preempts once the burst hits MAX_BURST.
    idle();
    for (int i = 1; i <= 20; i++) begin
      cycle(1, (i >= 3 && i <= 17), 0, 'h010, 0, 1, 1, 'h200 + i, 'hB000 + i);
      chk("burst_ack", 32'(host_ack), 32'(i != 17));
      chk("burst_stall", 32'(core_stall), 32'(i >= 3 && i <= 16));
    end

    // Host alone: 40 writes then 40 reads, never throttled.
    idle();
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0, 0, 0, 1, 1, i, pattern(i));
      chk("solo_wr_ack", 32'(host_ack), 32'd1);
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0, 0, 0, 1, 0, i, 0);
      chk("solo_rd_ack", 32'(host_ack), 32'd1);
      chk("solo_rd_data", 32'(host_rdata), 32'(pattern(i)));
    end

    // Reset asserted on host burst cycle 5 with core waiting: that write must not land.
    idle();
    for (int i = 1; i <= 5; i++) begin
      cycle((i != 5), (i == 5), 0, 0, 0, 1, 1, 'h300 + i, 'hC000 + i);
      if (i == 5) begin
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_ack", 32'(host_ack), 32'd0);
        chk("mid_rst_stall", 32'(core_stall), 32'd0);
      end
    end
    cycle(1, 1, 0, 'h304, 0, 1, 0, 0, 0);
    chk("post_rst_core", 32'(core_stall), 32'd0);
    chk("post_rst_rd4", 32'(core_rdata), 32'hC004);
    cycle(1, 1, 0, 'h305, 0, 0, 0, 0, 0);
    chk("post_rst_rd5", 32'(core_rdata), 32'h0000);

    // Randomized traffic with occasional resets over a small address window.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom_range(0, 63), $urandom,
            ($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
